id_regfile: RTL

Architectural general-purpose register file for the five-stage MIPS pipeline, sitting between write-back and decode. It is the write end of the decode read path. Write-back commits results into 32×32-bit storage. Decode reads two operands combinationally and feeds them to the decode-stage forwarding and hazard logic. A per-register pending scoreboard tracks in-flight writers, so decode can detect operands whose producer has not yet written back.

---
 rtl/id_regfile.sv | 72 +++++++
 1 files changed

// File: rtl/id_regfile.sv
// id_regfile: 31 x 32-bit architectural registers (r0 hardwired to zero), two
// combinational read ports and a per-register pending-writer scoreboard.
module id_regfile (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o,
  input  logic        issue_we_i,
  input  logic [4:0]  issue_waddr_i,
  input  logic        flush_i,
  output logic        pend1_o,
  output logic        pend2_o
);

  logic [31:0] r_regs [1:31];
  logic [31:1] r_pend;
  logic [31:1] w_pend_nxt;
  logic [31:0] w_pend_full;
  logic [31:0] w_rdata1;
  logic [31:0] w_rdata2;
  logic        w_wr_en;
  logic        w_iss_en;

  assign w_wr_en  = we_i && (waddr_i != 5'd0);
  assign w_iss_en = issue_we_i && (issue_waddr_i != 5'd0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 1; i < 32; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 1; i < 32; i++)
        if (w_wr_en && (waddr_i == 5'(i))) r_regs[i] <= wdata_i;
    end
  end

  // Clear first, then set, so a newer issue to the same register wins; flush beats both.
  always_comb begin
    w_pend_nxt = r_pend;
    for (int i = 1; i < 32; i++) begin
      if (w_wr_en && (waddr_i == 5'(i)))        w_pend_nxt[i] = 1'b0;
      if (w_iss_en && (issue_waddr_i == 5'(i))) w_pend_nxt[i] = 1'b1;
    end
    if (flush_i) w_pend_nxt = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_pend <= '0;
    else       r_pend <= w_pend_nxt;
  end

  always_comb begin
    w_rdata1 = '0;
    w_rdata2 = '0;
    for (int i = 1; i < 32; i++) begin
      if (raddr1_i == 5'(i)) w_rdata1 = r_regs[i];
      if (raddr2_i == 5'(i)) w_rdata2 = r_regs[i];
    end
  end

  assign w_pend_full = {r_pend, 1'b0};

  assign rdata1_o = rst_i ? 32'd0 : w_rdata1;
  assign rdata2_o = rst_i ? 32'd0 : w_rdata2;
  assign pend1_o  = ~rst_i & w_pend_full[raddr1_i];
  assign pend2_o  = ~rst_i & w_pend_full[raddr2_i];

endmodule
